// File: rtl/imem_loader_if.sv
// Bundle of the loader's control, byte-stream and instruction-memory write signals.
// The loader attaches to the slave modport; the driving side uses master.
interface imem_loader_if;
  logic        start;
  logic [7:0]  load_len;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, load_len, rx_data, rx_valid,
    input  rx_ready, mem_addr, mem_wdata, mem_we, cpu_hold, busy, done, err
  );

  modport slave (
    input  start, load_len, rx_data, rx_valid,
    output rx_ready, mem_addr, mem_wdata, mem_we, cpu_hold, busy, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Streams big-endian bytes into 32-bit instruction words and writes them to IMEM while holding the CPU.
// Optional trailing XOR checksum byte is enabled with `define LOADER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for start
// RECV  | accepting the bytes of the current word
// WRITE | one-cycle IMEM write strobe for the assembled word
// CHECK | accepting the checksum byte (LOADER_CHECKSUM_EN only)
// DONE  | one-cycle completion pulse
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;

  state_t      state_q;
  logic [7:0]  len_q;
  logic [8:0]  word_cnt_q;
  logic [1:0]  byte_cnt_q;
  logic [23:0] part_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        mem_we_q;
  logic        rx_ready_q;
  logic        cpu_hold_q;
  logic        busy_q;
  logic        done_q;
`ifdef LOADER_CHECKSUM_EN
  logic        err_q;
  logic [7:0]  csum_q;
`endif

  logic [31:0] word_d;
  logic [31:0] addr_d;
  logic        accept_d;
  logic        last_word_d;

  assign word_d      = {part_q, bus.rx_data};
  assign addr_d      = BASE_ADDR + {21'd0, word_cnt_q, 2'b00};
  assign accept_d    = bus.rx_valid && rx_ready_q;
  assign last_word_d = (word_cnt_q + 9'd1) == {1'b0, len_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      word_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      part_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rx_ready_q  <= 1'b0;
      cpu_hold_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      err_q       <= 1'b0;
      csum_q      <= '0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            cpu_hold_q <= 1'b1;
            busy_q     <= 1'b1;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            err_q      <= 1'b0;
            csum_q     <= '0;
`endif
            if (bus.load_len != 8'd0) begin
              len_q      <= bus.load_len;
              rx_ready_q <= 1'b1;
              state_q    <= RECV;
            end else begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        RECV: begin
          if (accept_d) begin
            part_q     <= word_d[23:0];
            byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_q ^ bus.rx_data;
`endif
            if (byte_cnt_q == 2'd3) begin
              rx_ready_q  <= 1'b0;
              mem_we_q    <= 1'b1;
              mem_wdata_q <= word_d;
              mem_addr_q  <= addr_d;
              state_q     <= WRITE;
            end
          end
        end
        WRITE: begin
          word_cnt_q <= word_cnt_q + 9'd1;
          if (last_word_d) begin
`ifdef LOADER_CHECKSUM_EN
            rx_ready_q <= 1'b1;
            state_q    <= CHECK;
`else
            done_q     <= 1'b1;
            state_q    <= DONE;
`endif
          end else begin
            rx_ready_q <= 1'b1;
            state_q    <= RECV;
          end
        end
        CHECK: begin
`ifdef LOADER_CHECKSUM_EN
          if (accept_d) begin
            if (bus.rx_data != csum_q) err_q <= 1'b1;
            rx_ready_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end
`else
          state_q <= IDLE;
`endif
        end
        DONE: begin
          cpu_hold_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.cpu_hold  = cpu_hold_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
`ifdef LOADER_CHECKSUM_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: inputs change and outputs are sampled on the falling edge.
// Checksum scenarios run only when LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imem_loader_if bus();

  imem_loader #(.BASE_ADDR(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  int          wr_total       = 0;
  int          done_total     = 0;
  int          hold_low_total = 0;
  int          rdy_total      = 0;
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];

  // Event counters sampled on the active edge, where registered outputs are stable.
  always @(posedge clk) begin
    if (bus.mem_we) begin
      wr_addr[wr_total % 64] <= bus.mem_addr;
      wr_data[wr_total % 64] <= bus.mem_wdata;
      wr_total <= wr_total + 1;
    end
    if (bus.done) done_total <= done_total + 1;
    if (bus.busy && !bus.cpu_hold) hold_low_total <= hold_low_total + 1;
    if (bus.rx_ready) rdy_total <= rdy_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic start_load(input logic [7:0] len);
    bus.load_len = len;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int g;
    g = 0;
    repeat (gap) @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) check("rx_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  // Advances from the last WRITE cycle to the DONE cycle.
  task automatic tail(input logic [7:0] csum);
`ifdef LOADER_CHECKSUM_EN
    send_byte(csum, 0);
`else
    if (csum === 8'hxx) $display("unused");
    @(negedge clk);
`endif
  endtask

  logic [7:0] s2 [12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                          8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
  logic [31:0] s2_words [3] = '{32'h11223344, 32'h55667788, 32'h99AABBCC};

  int base, d0, h0, r0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.load_len = 8'd0;
    bus.rx_data  = 8'd0;
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    check("rst_mem_we",   {31'd0, bus.mem_we},   32'd0);
    check("rst_mem_addr", bus.mem_addr,          32'd0);
    check("rst_mem_wdata",bus.mem_wdata,         32'd0);
    check("rst_busy",     {31'd0, bus.busy},     32'd0);
    check("rst_hold",     {31'd0, bus.cpu_hold}, 32'd0);
    check("rst_done",     {31'd0, bus.done},     32'd0);
    check("rst_err",      {31'd0, bus.err},      32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // One word, back-to-back bytes
    base = wr_total;
    start_load(8'd1);
    check("s1_busy",     {31'd0, bus.busy},     32'd1);
    check("s1_hold",     {31'd0, bus.cpu_hold}, 32'd1);
    check("s1_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
    send_byte(8'h8C, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    check("s1_we",       {31'd0, bus.mem_we},   32'd1);
    check("s1_addr",     bus.mem_addr,          32'h0);
    check("s1_data",     bus.mem_wdata,         32'h8C010004);
    check("s1_rdy_write",{31'd0, bus.rx_ready}, 32'd0);
    check("s1_done_early",{31'd0, bus.done},    32'd0);
    tail(8'h89);
    check("s1_done",     {31'd0, bus.done},     32'd1);
    check("s1_we_low",   {31'd0, bus.mem_we},   32'd0);
    check("s1_data_hold",bus.mem_wdata,         32'h8C010004);
    check("s1_hold_done",{31'd0, bus.cpu_hold}, 32'd1);
    @(negedge clk);
    check("s1_done_pulse",{31'd0, bus.done},    32'd0);
    check("s1_idle_busy",{31'd0, bus.busy},     32'd0);
    check("s1_idle_hold",{31'd0, bus.cpu_hold}, 32'd0);
    check("s1_err",      {31'd0, bus.err},      32'd0);
    check("s1_nwrites",  wr_total - base,       32'd1);

    // Three words with rx_valid gaps
    base = wr_total; d0 = done_total; h0 = hold_low_total;
    start_load(8'd3);
    for (int i = 0; i < 12; i++) send_byte(s2[i], i % 6);
    tail(8'hCC);
    check("s2_done", {31'd0, bus.done}, 32'd1);
    repeat (3) @(negedge clk);
    check("s2_nwrites", wr_total - base, 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("s2_addr%0d", i), wr_addr[(base + i) % 64], 32'(4 * i));
      check($sformatf("s2_data%0d", i), wr_data[(base + i) % 64], s2_words[i]);
    end
    check("s2_ndone",    done_total - d0,     32'd1);
    check("s2_hold_low", hold_low_total - h0, 32'd0);

    // Zero-length load
    base = wr_total; r0 = rdy_total;
    start_load(8'd0);
    check("s3_done",     {31'd0, bus.done},     32'd1);
    check("s3_busy",     {31'd0, bus.busy},     32'd1);
    check("s3_hold",     {31'd0, bus.cpu_hold}, 32'd1);
    @(negedge clk);
    check("s3_done_pulse",{31'd0, bus.done},    32'd0);
    check("s3_idle",     {31'd0, bus.busy},     32'd0);
    @(negedge clk);
    check("s3_nwrites",  wr_total - base,       32'd0);
    check("s3_rx_ready", rdy_total - r0,        32'd0);

    // Reset in the middle of word 2
    base = wr_total;
    start_load(8'd3);
    send_byte(8'hA1, 0);
    send_byte(8'hA2, 0);
    send_byte(8'hA3, 0);
    send_byte(8'hA4, 0);
    send_byte(8'hB1, 0);
    send_byte(8'hB2, 0);
    rst_n = 1'b0;
    #1;
    check("s4_rst_addr",  bus.mem_addr,          32'd0);
    check("s4_rst_data",  bus.mem_wdata,         32'd0);
    check("s4_rst_busy",  {31'd0, bus.busy},     32'd0);
    check("s4_rst_hold",  {31'd0, bus.cpu_hold}, 32'd0);
    check("s4_rst_ready", {31'd0, bus.rx_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("s4_nwrites_pre", wr_total - base, 32'd1);
    base = wr_total;
    start_load(8'd1);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hEF, 0);
    check("s4_addr", bus.mem_addr,  32'h0);
    check("s4_data", bus.mem_wdata, 32'hDEADBEEF);
    tail(8'h22);
    check("s4_done", {31'd0, bus.done}, 32'd1);
    repeat (2) @(negedge clk);
    check("s4_nwrites", wr_total - base, 32'd1);

    // start pulses while busy are ignored
    base = wr_total;
    start_load(8'd2);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    bus.load_len = 8'd5;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    send_byte(8'h05, 0);
    send_byte(8'h06, 0);
    send_byte(8'h07, 0);
    send_byte(8'h08, 0);
    tail(8'h08);
    check("s6_done", {31'd0, bus.done}, 32'd1);
    repeat (2) @(negedge clk);
    check("s6_nwrites", wr_total - base, 32'd2);
    check("s6_addr1",   wr_addr[(base + 1) % 64], 32'h4);
    check("s6_data1",   wr_data[(base + 1) % 64], 32'h05060708);
    check("s6_busy",    {31'd0, bus.busy}, 32'd0);

`ifdef LOADER_CHECKSUM_EN
    start_load(8'd1);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h56, 0);
    send_byte(8'h78, 0);
    send_byte(8'h08, 0);
    check("cs_ok_done", {31'd0, bus.done}, 32'd1);
    check("cs_ok_err",  {31'd0, bus.err},  32'd0);
    @(negedge clk);
    start_load(8'd1);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h56, 0);
    send_byte(8'h78, 0);
    send_byte(8'h09, 0);
    check("cs_bad_done", {31'd0, bus.done}, 32'd1);
    check("cs_bad_err",  {31'd0, bus.err},  32'd1);
    repeat (4) @(negedge clk);
    check("cs_err_held", {31'd0, bus.err},  32'd1);
    start_load(8'd0);
    check("cs_err_clr",  {31'd0, bus.err},  32'd0);
    @(negedge clk);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
